// File: rtl/esm_dep_pkg.sv
// ---------------------------------------------------------------------------
// esm_dep_pkg
// Shared helpers for the ESM dependency tracker.
//   - MAX_SLOTS / MAX_IDXW : widest slot vector the helper functions handle
//                            (the tracker supports BS up to MAX_SLOTS).
//   - MAX_RAW_W            : widest register address held in a slot record.
//   - REG0                 : the hard-zero architectural register.
//   - slot_rec_t           : per-slot source operand record, only stored when
//                            the ESM_WAW_WAR_EN build option is defined.
//   - onehot / lowest_set / popcount : slot-vector helpers.
// ---------------------------------------------------------------------------
package esm_dep_pkg;

    localparam int unsigned MAX_SLOTS = 64;
    localparam int unsigned MAX_IDXW  = 6;
    localparam int unsigned MAX_RAW_W = 8;
    localparam int unsigned REG0      = 0;

    typedef logic [MAX_SLOTS-1:0] slot_vec_t;

    typedef struct packed {
        logic [MAX_RAW_W-1:0] rs1;
        logic [MAX_RAW_W-1:0] rs2;
        logic                 rs1_en;
        logic                 rs2_en;
    } slot_rec_t;

    function automatic slot_vec_t onehot(input logic [MAX_IDXW-1:0] idx);
        return slot_vec_t'(1'b1) << idx;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [MAX_IDXW-1:0] lowest_set(input slot_vec_t v);
        logic [MAX_IDXW-1:0] r;
        r = '0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (v[i]) r = MAX_IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [MAX_IDXW:0] popcount(input slot_vec_t v);
        logic [MAX_IDXW:0] c;
        c = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            c = c + {{MAX_IDXW{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/esm_dep_tracker_if.sv
// ---------------------------------------------------------------------------
// esm_dep_tracker_if
// Bus between decode/issue logic (master) and the dependency tracker (slave).
//   flush                         : clear tracker next edge
//   alloc_valid/ready/idx         : allocation handshake and chosen slot
//   alloc_rd/_en, alloc_rs1/_en,
//   alloc_rs2/_en                 : register operands of the new instruction
//   issue_valid/idx/ready         : issue handshake (lowest ready slot)
//   comp_valid/idx                : completion of an issued slot
//   ready_vec, occupancy, comp_err: status outputs
// ---------------------------------------------------------------------------
interface esm_dep_tracker_if #(
    parameter int BS     = 16,
    parameter int REGNUM = 32
);
    localparam int IDXW  = $clog2(BS);
    localparam int RAW_W = $clog2(REGNUM);

    logic             flush;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [IDXW-1:0]  alloc_idx;
    logic [RAW_W-1:0] alloc_rd;
    logic             alloc_rd_en;
    logic [RAW_W-1:0] alloc_rs1;
    logic             alloc_rs1_en;
    logic [RAW_W-1:0] alloc_rs2;
    logic             alloc_rs2_en;
    logic             issue_valid;
    logic [IDXW-1:0]  issue_idx;
    logic             issue_ready;
    logic             comp_valid;
    logic [IDXW-1:0]  comp_idx;
    logic [BS-1:0]    ready_vec;
    logic [IDXW:0]    occupancy;
    logic             comp_err;

    modport master (
        output flush, alloc_valid, alloc_rd, alloc_rd_en, alloc_rs1, alloc_rs1_en,
               alloc_rs2, alloc_rs2_en, issue_ready, comp_valid, comp_idx,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, ready_vec,
               occupancy, comp_err
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_rd_en, alloc_rs1, alloc_rs1_en,
               alloc_rs2, alloc_rs2_en, issue_ready, comp_valid, comp_idx,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, ready_vec,
               occupancy, comp_err
    );

endinterface

// File: rtl/esm_prio_enc.sv
// ---------------------------------------------------------------------------
// esm_prio_enc
// W-wide lowest-set-bit priority encoder.
//   req_i : request vector
//   any_o : at least one request bit set
//   idx_o : index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module esm_prio_enc
    import esm_dep_pkg::*;
#(
    parameter int W    = 16,
    parameter int IDXW = $clog2(W)
) (
    input  logic [W-1:0]    req_i,
    output logic            any_o,
    output logic [IDXW-1:0] idx_o
);

    assign any_o = |req_i;
    assign idx_o = IDXW'(lowest_set(slot_vec_t'(req_i)));

endmodule

// File: rtl/esm_dep_tracker.sv
// ---------------------------------------------------------------------------
// esm_dep_tracker
// Tracks up to BS in-flight instructions between decode and issue. A register
// producer table turns each new instruction's sources into a row of the
// dependency matrix (row = consumer, column = producer); completing a slot
// clears its column and retires it from the producer table.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : esm_dep_tracker_if slave (allocate / issue / complete / status)
// Build option ESM_WAW_WAR_EN: adds WAW (current producer of rd) and WAR
// (valid, unissued readers of rd) terms, using stored per-slot source records.
// BS must be a power of two, 2 <= BS <= esm_dep_pkg::MAX_SLOTS.
// ---------------------------------------------------------------------------
module esm_dep_tracker
    import esm_dep_pkg::*;
#(
    parameter int BS     = 16,
    parameter int REGNUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    esm_dep_tracker_if.slave  bus
);

    localparam int IDXW  = $clog2(BS);
    localparam int RAW_W = $clog2(REGNUM);

    logic [BS-1:0]    valid_q, valid_d;
    logic [BS-1:0]    issued_q, issued_d;
    logic [BS-1:0]    dep_q [BS];
    logic [BS-1:0]    dep_d [BS];
    logic [REGNUM-1:0] prod_v_q, prod_v_d;
    logic [IDXW-1:0]  prod_idx_q [REGNUM];
    logic [IDXW-1:0]  prod_idx_d [REGNUM];
    logic [IDXW:0]    occ_q, occ_d;
    logic             comp_err_q, comp_err_d;
`ifdef ESM_WAW_WAR_EN
    slot_rec_t        rec_q [BS];
    slot_rec_t        rec_d [BS];
`endif

    logic [BS-1:0]    free_vec;
    logic [BS-1:0]    ready_vec;
    logic             alloc_ready, issue_valid;
    logic [IDXW-1:0]  alloc_idx, issue_idx, comp_k;
    logic             alloc_fire, issue_fire, comp_ok;
    logic [BS-1:0]    row_new;

    function automatic logic [BS-1:0] slot_bit(input logic [IDXW-1:0] idx);
        return BS'(onehot(MAX_IDXW'(idx)));
    endfunction

    assign free_vec = ~valid_q;

    esm_prio_enc #(.W(BS), .IDXW(IDXW)) u_free_sel (
        .req_i (free_vec),
        .any_o (alloc_ready),
        .idx_o (alloc_idx)
    );

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < BS; i++) begin
            ready_vec[i] = valid_q[i] & ~issued_q[i] & ~(|dep_q[i]);
        end
    end

    esm_prio_enc #(.W(BS), .IDXW(IDXW)) u_issue_sel (
        .req_i (ready_vec),
        .any_o (issue_valid),
        .idx_o (issue_idx)
    );

    assign comp_k     = bus.comp_idx;
    assign comp_ok    = bus.comp_valid & valid_q[comp_k] & issued_q[comp_k];
    assign alloc_fire = bus.alloc_valid & alloc_ready;
    assign issue_fire = issue_valid & bus.issue_ready;

    always_comb begin
        valid_d    = valid_q;
        issued_d   = issued_q;
        dep_d      = dep_q;
        prod_v_d   = prod_v_q;
        prod_idx_d = prod_idx_q;
        row_new    = '0;
        comp_err_d = bus.comp_valid & ~comp_ok;
`ifdef ESM_WAW_WAR_EN
        rec_d      = rec_q;
`endif

        if (comp_ok) begin
            valid_d[comp_k]  = 1'b0;
            issued_d[comp_k] = 1'b0;
            for (int i = 0; i < BS; i++) dep_d[i][comp_k] = 1'b0;
            for (int r = 0; r < REGNUM; r++) begin
                if (prod_v_q[r] && prod_idx_q[r] == comp_k) prod_v_d[r] = 1'b0;
            end
        end

        // The issued slot is never the completing one (that one is already issued).
        if (issue_fire) issued_d[issue_idx] = 1'b1;

        if (alloc_fire) begin
            // A producer completing this same edge is bypassed: no dep bit on it.
            if (bus.alloc_rs1_en && bus.alloc_rs1 != RAW_W'(REG0) && prod_v_q[bus.alloc_rs1]
                && !(comp_ok && prod_idx_q[bus.alloc_rs1] == comp_k))
                row_new = row_new | slot_bit(prod_idx_q[bus.alloc_rs1]);
            if (bus.alloc_rs2_en && bus.alloc_rs2 != RAW_W'(REG0) && prod_v_q[bus.alloc_rs2]
                && !(comp_ok && prod_idx_q[bus.alloc_rs2] == comp_k))
                row_new = row_new | slot_bit(prod_idx_q[bus.alloc_rs2]);
`ifdef ESM_WAW_WAR_EN
            if (bus.alloc_rd_en && bus.alloc_rd != RAW_W'(REG0)) begin
                if (prod_v_q[bus.alloc_rd] && !(comp_ok && prod_idx_q[bus.alloc_rd] == comp_k))
                    row_new = row_new | slot_bit(prod_idx_q[bus.alloc_rd]);
                for (int j = 0; j < BS; j++) begin
                    if (valid_q[j] && !issued_q[j] &&
                        ((rec_q[j].rs1_en && rec_q[j].rs1 == MAX_RAW_W'(bus.alloc_rd)) ||
                         (rec_q[j].rs2_en && rec_q[j].rs2 == MAX_RAW_W'(bus.alloc_rd))))
                        row_new[j] = 1'b1;
                end
            end
            rec_d[alloc_idx] = '{rs1:    MAX_RAW_W'(bus.alloc_rs1),
                                 rs2:    MAX_RAW_W'(bus.alloc_rs2),
                                 rs1_en: bus.alloc_rs1_en,
                                 rs2_en: bus.alloc_rs2_en};
`endif
            valid_d[alloc_idx]  = 1'b1;
            issued_d[alloc_idx] = 1'b0;
            dep_d[alloc_idx]    = row_new;
            // Applied after the completion clear, so the new producer wins.
            if (bus.alloc_rd_en && bus.alloc_rd != RAW_W'(REG0)) begin
                prod_v_d[bus.alloc_rd]   = 1'b1;
                prod_idx_d[bus.alloc_rd] = alloc_idx;
            end
        end

        if (bus.flush) begin
            valid_d    = '0;
            issued_d   = '0;
            prod_v_d   = '0;
            comp_err_d = 1'b0;
            for (int i = 0; i < BS; i++) dep_d[i] = '0;
            for (int r = 0; r < REGNUM; r++) prod_idx_d[r] = '0;
        end

        occ_d = (IDXW+1)'(popcount(slot_vec_t'(valid_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            issued_q   <= '0;
            prod_v_q   <= '0;
            occ_q      <= '0;
            comp_err_q <= 1'b0;
            for (int i = 0; i < BS; i++) dep_q[i] <= '0;
            for (int r = 0; r < REGNUM; r++) prod_idx_q[r] <= '0;
        end else begin
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            prod_v_q   <= prod_v_d;
            occ_q      <= occ_d;
            comp_err_q <= comp_err_d;
            dep_q      <= dep_d;
            prod_idx_q <= prod_idx_d;
        end
    end

`ifdef ESM_WAW_WAR_EN
    // Source records are payload, read only while their slot is valid.
    always_ff @(posedge clk) begin
        rec_q <= rec_d;
    end
`endif

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc_idx   = alloc_idx;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_idx   = issue_idx;
    assign bus.ready_vec   = ready_vec;
    assign bus.occupancy   = occ_q;
    assign bus.comp_err    = comp_err_q;

endmodule

// File: doc/esm_dep_tracker.md
Name: esm_dep_tracker

Overview:
- Parametrised successor to the single-table ESM dependency core: tracks up to BS in-flight instructions, builds RAW dependencies through a register-producer table, and clears them on completion.
- Adds slot allocation, an issue handshake, completion/wake-up, flush and occupancy.
- Sits between decode (allocate) and the execute/issue stage of the ESM module.

Parameters:
- BS, 16, buffer depth (slots); power of two, >=2
- REGNUM, 32, architectural registers; register 0 is hard-zero
- IDXW, $clog2(BS), slot index width (derived, localparam)
- RAW_W, $clog2(REGNUM), register address width (derived, localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  clears all slots and tables next edge
- alloc_valid  in  1  decode offers an instruction
- alloc_ready  out  1  a free slot exists
- alloc_idx  out  IDXW  slot that will be used (lowest free index)
- alloc_rd  in  RAW_W  destination register
- alloc_rd_en  in  1  instruction writes rd
- alloc_rs1  in  RAW_W  source 1
- alloc_rs1_en  in  1  rs1 used
- alloc_rs2  in  RAW_W  source 2
- alloc_rs2_en  in  1  rs2 used (0 for immediate forms)
- issue_valid  out  1  some slot ready
- issue_idx  out  IDXW  lowest-index ready slot
- issue_ready  in  1  consumer accepts issue_idx
- comp_valid  in  1  an issued slot completes
- comp_idx  in  IDXW  completing slot
- ready_vec  out  BS  per-slot ready (valid & ~issued & no deps)
- occupancy  out  IDXW+1  valid slot count
- comp_err  out  1  pulse: completion on non-issued slot (ignored)

Behaviour:
- State: valid[BS], issued[BS], dep matrix dep[BS][BS] (row = consumer, column = producer), producer table prod_v[REGNUM], prod_idx[REGNUM].
- Reset or flush: all state 0. Outputs: alloc_ready=1, alloc_idx=0, issue_valid=0, ready_vec=0, occupancy=0, comp_err=0. Flush has priority over all same-cycle events.
- Allocation fires on alloc_valid & alloc_ready. Slot s=alloc_idx:
  - valid[s]=1, issued[s]=0.
  - dep row s = onehot(prod_idx[rs1]) if rs1_en & rs1!=0 & prod_v[rs1], OR the same term for rs2.
  - If rd_en & rd!=0: prod_v[rd]=1, prod_idx[rd]=s.
- alloc_valid while full: no state change.
- Issue fires on issue_valid & issue_ready: issued[issue_idx]=1. issue_idx and issue_valid are combinational from registered state. A newly allocated slot is issuable the cycle after allocation at the earliest.
- Completion of slot k (comp_valid & valid[k] & issued[k]):
  - clear column k in all rows; valid[k]=0.
  - for every register r with prod_v[r] & prod_idx[r]==k: prod_v[r]=0.
  - Completion on a slot not valid or not issued: ignored; comp_err=1 for one cycle.
- Simultaneous allocate and complete:
  - A source whose producer is the completing slot k must not set dep bit k (bypass).
  - If the allocating rd also targets a register whose producer is k, the allocation's producer write wins.
- alloc_ready/alloc_idx reflect registered state only; a slot freed this cycle is allocatable next cycle.
- Simultaneous issue and completion of different slots are independent.
- occupancy = popcount(valid), registered, updated the same edge as valid.
- A slot never depends on itself; dep bits only ever reference valid slots.

Optional Feature:
- Macro ESM_WAW_WAR_EN.
- Defined: the dep row additionally includes
  - WAW: the current producer of rd.
  - WAR: every valid, not-issued slot reading rd. This needs stored per-slot rs1/rs2/enable fields.
- Undefined: RAW only. Those fields are not instantiated.

Decomposition:
- Package esm_dep_pkg: helper functions onehot and lowest_set (priority encode), popcount, the REG0 constant, and a slot-record typedef {rs1, rs2, rs1_en, rs2_en}.
- One sub-module: esm_prio_enc (BS-wide lowest-set-bit encoder with any-valid output), instanced twice: free-slot select and issue select.

Test Plan:
- Reset, then allocate add x3<-x1,x2 -> alloc_idx=0, next cycle ready_vec[0]=1, issue_valid=1, issue_idx=0, occupancy=1.
- Allocate x5<-x3 (slot 1) after slot 0 writes x3 -> dep[1][0]=1, ready_vec[1]=0. Issue+complete slot 0 -> next cycle ready_vec[1]=1.
- Allocate a reader of x3 in the same cycle slot 0 completes -> no dependency, ready next cycle.
- Fill 16 slots -> alloc_ready=0, occupancy=16; further alloc_valid ignored. Complete slot 7 -> alloc_idx=7 next cycle.
- comp_valid on an unissued slot 2 -> comp_err pulse, state unchanged. Flush with 5 valid slots -> occupancy=0, issue_valid=0 next cycle.
- rs = x0 and rs2_en=0 with x0/prod tables populated -> no dep bits set. With ESM_WAW_WAR_EN, second writer of x4 depends on the first writer.
